pastassert_launcher: RTL and testbench

Upstream launch stage for the `PastAssert` countdown block. It queues start requests, each carrying a tag, in a small FIFO. It fires `startSignal` once per request when the countdown block is ready, then watches `busy` through the whole countdown. For each request it emits one completion record, carrying the tag and a timeout flag, to a downstream consumer.

---
 rtl/pastassert_launcher_pkg.sv | 26 ++
 rtl/pastassert_launcher_tag_fifo.sv | 79 +++++++
 rtl/pastassert_launcher.sv | 148 ++++++++++++++
 tb/tb_pastassert_launcher.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pastassert_launcher_pkg.sv
// -----------------------------------------------------------------------------
// pastassert_launcher_pkg
// Shared types and default constants for the PastAssert launch stage.
//   launcher_state_t : FSM states of the launcher
//   done_rec_t       : completion record layout {tag, timeout}, timeout in LSB
//   DEPTH/TAG_W/TIMEOUT : default parameter values for the top
// -----------------------------------------------------------------------------
package pastassert_launcher_pkg;

  localparam int DEPTH   = 4;
  localparam int TAG_W   = 4;
  localparam int TIMEOUT = 64;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    REPORT    = 2'd3
  } launcher_state_t;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic             timeout;
  } done_rec_t;

endpackage

// File: rtl/pastassert_launcher_tag_fifo.sv
// -----------------------------------------------------------------------------
// tag_fifo
// Synchronous DEPTH x TAG_W FIFO holding queued request tags.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i/data_i : write request and data (ignored while full)
//   pop_i/data_o  : read request (ignored while empty), head-of-queue data
//   full_o/empty_o: occupancy flags
//   count_o       : number of stored entries
// -----------------------------------------------------------------------------
module tag_fifo #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [TAG_W-1:0]           data_i,
  input  logic                       pop_i,
  output logic [TAG_W-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [TAG_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (count_q == CNT_FULL);
  assign empty_o   = (count_q == {CW{1'b0}});
  assign count_o   = count_q;
  assign data_o    = mem_q[rd_ptr_q];
  // A full FIFO refuses a push even when a pop happens in the same cycle.
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;

  // Storage array and pointers; power-of-two depth lets pointers wrap naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {TAG_W{1'b0}};
      end
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
    end else begin
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop_ok_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  // Occupancy counter; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= {CW{1'b0}};
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/pastassert_launcher.sv
// -----------------------------------------------------------------------------
// pastassert_launcher
// Launch stage for the PastAssert countdown block. Queues tagged start
// requests, fires one startSignal per request when the countdown block is
// idle, follows busy through the countdown and emits one completion record
// {tag, timeout} per request.
//   CLK, nRST                    : clock, asynchronous active-low reset
//   req__ENA/req_v/req__RDY      : request enqueue handshake and tag
//   startSignal__ENA/__RDY       : start pulse / countdown block idle
//   busy, busy__RDY              : countdown status and its valid
//   done__ENA/done_v/done__RDY   : completion record handshake
//   pending                      : request FIFO occupancy
// -----------------------------------------------------------------------------
module pastassert_launcher #(
  parameter int DEPTH   = pastassert_launcher_pkg::DEPTH,
  parameter int TAG_W   = pastassert_launcher_pkg::TAG_W,
  parameter int TIMEOUT = pastassert_launcher_pkg::TIMEOUT
) (
  input  logic                       CLK,
  input  logic                       nRST,
  input  logic                       req__ENA,
  input  logic [TAG_W-1:0]           req_v,
  output logic                       req__RDY,
  output logic                       startSignal__ENA,
  input  logic                       startSignal__RDY,
  input  logic                       busy,
  input  logic                       busy__RDY,
  output logic                       done__ENA,
  output logic [TAG_W:0]             done_v,
  input  logic                       done__RDY,
  output logic [$clog2(DEPTH+1)-1:0] pending
);

  import pastassert_launcher_pkg::*;

  localparam int TW = $clog2(TIMEOUT);

  localparam logic [TW-1:0] TIMER_ONE = TW'(1);
  localparam logic [TW-1:0] TIMER_MAX = {TW{1'b1}};
  // The timer value that, once incremented, reaches TIMEOUT-1; leaving on it
  // puts the record in REPORT exactly TIMEOUT cycles after the issue cycle.
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 2);

  launcher_state_t              state_q;
  logic [TW-1:0]                timer_q;
  logic [TW-1:0]                timer_d;
  logic [TAG_W-1:0]             cur_tag_q;
  logic                         to_flag_q;

  logic                         fifo_full_s;
  logic                         fifo_empty_s;
  logic [TAG_W-1:0]             fifo_tag_s;
  logic [$clog2(DEPTH+1)-1:0]   fifo_count_s;
  logic                         fire_s;
  logic                         timeout_hit_s;
  logic                         busy_rise_s;
  logic                         busy_fall_s;

  tag_fifo #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_tag_fifo (
    .clk_i   (CLK),
    .rst_ni  (nRST),
    .push_i  (req__ENA),
    .data_i  (req_v),
    .pop_i   (fire_s),
    .data_o  (fifo_tag_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  assign req__RDY = !fifo_full_s;
  assign pending  = fifo_count_s;

  // Issue only from IDLE; the FIFO is never bypassed, so a fresh push waits a cycle.
  assign fire_s = (state_q == IDLE) && !fifo_empty_s && startSignal__RDY && busy__RDY;
  assign startSignal__ENA = fire_s;

  assign busy_rise_s   = busy__RDY && busy;
  assign busy_fall_s   = busy__RDY && !busy;
  // >= keeps the timeout reachable even if the timer has already saturated.
  assign timeout_hit_s = (timer_q >= TIMER_LAST);

  assign done__ENA = (state_q == REPORT) && done__RDY;
  assign done_v    = (state_q == REPORT) ? {cur_tag_q, to_flag_q} : {(TAG_W+1){1'b0}};

  // Saturating timer increment.
  always_comb begin
    timer_d = timer_q;
    if (timer_q == TIMER_MAX) begin
      timer_d = timer_q;
    end else begin
      timer_d = timer_q + TIMER_ONE;
    end
  end

  // Launcher FSM with timer, current tag and timeout flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      timer_q   <= {TW{1'b0}};
      cur_tag_q <= {TAG_W{1'b0}};
      to_flag_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (fire_s) begin
            state_q   <= WAIT_BUSY;
            timer_q   <= {TW{1'b0}};
            cur_tag_q <= fifo_tag_s;
            to_flag_q <= 1'b0;
          end
        end
        WAIT_BUSY: begin
          timer_q <= timer_d;
          if (timeout_hit_s) begin
            state_q   <= REPORT;
            to_flag_q <= 1'b1;
          end else if (busy_rise_s) begin
            state_q <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          timer_q <= timer_d;
          // A completion seen in the timeout cycle still counts as completion.
          if (busy_fall_s) begin
            state_q   <= REPORT;
            to_flag_q <= 1'b0;
          end else if (timeout_hit_s) begin
            state_q   <= REPORT;
            to_flag_q <= 1'b1;
          end
        end
        REPORT: begin
          if (done__RDY) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pastassert_launcher.sv
// -----------------------------------------------------------------------------
// tb_pastassert_launcher
// Bench for pastassert_launcher with a behavioural PastAssert countdown model
// and a scoreboard of expected completion records.
// -----------------------------------------------------------------------------
module tb_pastassert_launcher;
  import pastassert_launcher_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST = 1'b0;
  logic       req__ENA = 1'b0;
  logic [3:0] req_v = 4'h0;
  logic       req__RDY;
  logic       startSignal__ENA;
  logic       startSignal__RDY;
  logic       busy;
  logic       busy__RDY = 1'b1;
  logic       done__ENA;
  logic [4:0] done_v;
  logic       done__RDY = 1'b1;
  logic [2:0] pending;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int n_start = 0;
  int n_done = 0;
  int start_cyc = 0;
  int done_cyc = 0;
  logic [4:0] exp_q [$];

  // countdown model knobs and state
  int   max_amt = 22;
  int   cnt = 0;
  logic hang_arm = 1'b0;
  logic hang_clr = 1'b0;
  logic hung = 1'b0;

  pastassert_launcher dut (
    .CLK              (CLK),
    .nRST             (nRST),
    .req__ENA         (req__ENA),
    .req_v            (req_v),
    .req__RDY         (req__RDY),
    .startSignal__ENA (startSignal__ENA),
    .startSignal__RDY (startSignal__RDY),
    .busy             (busy),
    .busy__RDY        (busy__RDY),
    .done__ENA        (done__ENA),
    .done_v           (done_v),
    .done__RDY        (done__RDY),
    .pending          (pending)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // PastAssert countdown model: loads max_amt on start, counts down to 0.
  always @(posedge CLK) begin
    if (startSignal__ENA) cnt <= max_amt;
    else if (cnt != 0) cnt <= cnt - 1;
    if (hang_clr) hung <= 1'b0;
    else if (startSignal__ENA && hang_arm) hung <= 1'b1;
  end
  assign busy             = hung || (cnt != 0);
  assign startSignal__RDY = !hung && (cnt == 0);

  function automatic logic [4:0] rec(input logic [3:0] t, input logic to);
    done_rec_t r;
    r.tag = t;
    r.timeout = to;
    return r;
  endfunction

  // Monitor: start pulses and scoreboard compare of accepted records.
  always @(negedge CLK) begin
    if (nRST) begin
      if (startSignal__ENA) begin
        n_start++;
        start_cyc = cyc;
        tests_run++;
        if (startSignal__RDY !== 1'b1) begin
          tests_failed++;
          $display("FAIL start_while_not_ready: startSignal__RDY=%b, required 1", startSignal__RDY);
        end
      end
      if (done__ENA) begin
        n_done++;
        done_cyc = cyc;
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("FAIL done_unexpected: got record 0x%0h, none expected", done_v);
        end else begin
          logic [4:0] e;
          e = exp_q.pop_front();
          if (done_v !== e) begin
            tests_failed++;
            $display("FAIL done_record: got 0x%0h, expected 0x%0h", done_v, e);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive a request for the coming edge; expect a record only if accepted.
  task automatic drive_req(input logic [3:0] tag, input logic to);
    req__ENA = 1'b1;
    req_v = tag;
    if (req__RDY === 1'b1) exp_q.push_back(rec(tag, to));
  endtask

  task automatic wait_done(input int prev, input int budget, input string name);
    int k = 0;
    while (n_done <= prev && k < budget) begin
      tick(1);
      k++;
    end
    tests_run++;
    if (n_done <= prev) begin
      tests_failed++;
      $display("FAIL %s_wait: n_done=%0d, required >%0d within %0d cycles", name, n_done, prev, budget);
    end
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    tick(2);
    tests_run++;
    if (req__RDY !== 1'b1) begin tests_failed++; $display("FAIL reset_req_rdy: got %b, expected 1", req__RDY); end
    tests_run++;
    if (startSignal__ENA !== 1'b0) begin tests_failed++; $display("FAIL reset_start: got %b, expected 0", startSignal__ENA); end
    tests_run++;
    if (done__ENA !== 1'b0) begin tests_failed++; $display("FAIL reset_done_ena: got %b, expected 0", done__ENA); end
    tests_run++;
    if (done_v !== 5'h00) begin tests_failed++; $display("FAIL reset_done_v: got 0x%0h, expected 0x0", done_v); end
    tests_run++;
    if (pending !== 3'd0) begin tests_failed++; $display("FAIL reset_pending: got %0d, expected 0", pending); end
    nRST = 1'b1;
    tick(2);
  endtask

  task automatic test_single;
    int s0 = n_start;
    int d0 = n_done;
    max_amt = 22;
    drive_req(4'h3, 1'b0);
    tests_run++;
    if (startSignal__ENA !== 1'b0) begin tests_failed++; $display("FAIL single_no_bypass: start=%b, expected 0", startSignal__ENA); end
    tick(1);
    req__ENA = 1'b0;
    tests_run++;
    if (pending !== 3'd1) begin tests_failed++; $display("FAIL single_pending1: got %0d, expected 1", pending); end
    tests_run++;
    if (startSignal__ENA !== 1'b1) begin tests_failed++; $display("FAIL single_issue_latency: start=%b, expected 1", startSignal__ENA); end
    wait_done(d0, 200, "single");
    tests_run++;
    if (done_cyc - start_cyc !== 24) begin tests_failed++; $display("FAIL single_latency: got %0d cycles, expected 24", done_cyc - start_cyc); end
    tests_run++;
    if (n_start - s0 !== 1) begin tests_failed++; $display("FAIL single_pulses: got %0d, expected 1", n_start - s0); end
    tests_run++;
    if (pending !== 3'd0) begin tests_failed++; $display("FAIL single_pending0: got %0d, expected 0", pending); end
  endtask

  task automatic test_back_to_back;
    int s0 = n_start;
    int d0 = n_done;
    max_amt = 5;
    busy__RDY = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      if (i == 5) begin
        tests_run++;
        if (req__RDY !== 1'b0) begin tests_failed++; $display("FAIL b2b_full_rdy: got %b, expected 0", req__RDY); end
      end
      drive_req(4'(i), 1'b0);
      tick(1);
    end
    req__ENA = 1'b0;
    tests_run++;
    if (pending !== 3'd4) begin tests_failed++; $display("FAIL b2b_pending_full: got %0d, expected 4", pending); end
    busy__RDY = 1'b1;
    wait_done(d0 + 3, 400, "b2b");
    tick(2);
    tests_run++;
    if (n_start - s0 !== 4) begin tests_failed++; $display("FAIL b2b_pulses: got %0d, expected 4", n_start - s0); end
    tests_run++;
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL b2b_leftover: %0d records outstanding, expected 0", exp_q.size()); end
    tests_run++;
    if (pending !== 3'd0) begin tests_failed++; $display("FAIL b2b_pending0: got %0d, expected 0", pending); end
  endtask

  task automatic test_timeout;
    int s0 = n_start;
    int d0 = n_done;
    max_amt = 5;
    hang_arm = 1'b1;
    drive_req(4'hA, 1'b1);
    tick(1);
    drive_req(4'hB, 1'b0);
    tick(1);
    req__ENA = 1'b0;
    wait_done(d0, 200, "timeout");
    hang_arm = 1'b0;
    tests_run++;
    if (done_cyc - start_cyc !== 64) begin tests_failed++; $display("FAIL timeout_latency: got %0d cycles, expected 64", done_cyc - start_cyc); end
    tick(20);
    tests_run++;
    if (n_start - s0 !== 1) begin tests_failed++; $display("FAIL timeout_no_reissue: got %0d pulses, expected 1", n_start - s0); end
    tests_run++;
    if (pending !== 3'd1) begin tests_failed++; $display("FAIL timeout_pending: got %0d, expected 1", pending); end
    hang_clr = 1'b1;
    tick(1);
    hang_clr = 1'b0;
    wait_done(d0 + 1, 100, "timeout_next");
    tests_run++;
    if (n_start - s0 !== 2) begin tests_failed++; $display("FAIL timeout_second: got %0d pulses, expected 2", n_start - s0); end
  endtask

  task automatic test_backpressure;
    int d0 = n_done;
    int k = 0;
    max_amt = 3;
    done__RDY = 1'b0;
    drive_req(4'h6, 1'b0);
    tick(1);
    drive_req(4'h7, 1'b0);
    tick(1);
    req__ENA = 1'b0;
    while (done_v === 5'h00 && k < 100) begin
      tick(1);
      k++;
    end
    tests_run++;
    if (done_v !== 5'h0C) begin tests_failed++; $display("FAIL bp_report: got 0x%0h, expected 0xc", done_v); end
    for (int c = 0; c < 10; c++) begin
      tests_run++;
      if (done_v !== 5'h0C || startSignal__ENA !== 1'b0 || done__ENA !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold c%0d: done_v=0x%0h start=%b ena=%b, expected 0xc 0 0", c, done_v, startSignal__ENA, done__ENA);
      end
      tick(1);
    end
    done__RDY = 1'b1;
    #1;
    tests_run++;
    if (done__ENA !== 1'b1 || startSignal__ENA !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_accept: ena=%b start=%b, expected 1 0", done__ENA, startSignal__ENA);
    end
    tick(1);
    tests_run++;
    if (startSignal__ENA !== 1'b1) begin tests_failed++; $display("FAIL bp_next_issue: start=%b, expected 1", startSignal__ENA); end
    wait_done(d0 + 1, 100, "bp");
  endtask

  task automatic test_reset_midflight;
    int s0 = n_start;
    int d0 = n_done;
    max_amt = 30;
    drive_req(4'h8, 1'b0);
    tick(1);
    drive_req(4'h9, 1'b0);
    tick(1);
    drive_req(4'hD, 1'b0);
    tick(1);
    req__ENA = 1'b0;
    tick(3);
    tests_run++;
    if (pending !== 3'd2) begin tests_failed++; $display("FAIL rst_mid_pending_before: got %0d, expected 2", pending); end
    nRST = 1'b0;
    #1;
    exp_q.delete();
    tests_run++;
    if (req__RDY !== 1'b1 || startSignal__ENA !== 1'b0 || done__ENA !== 1'b0 || done_v !== 5'h00 || pending !== 3'd0) begin
      tests_failed++;
      $display("FAIL rst_mid_outputs: rdy=%b start=%b ena=%b v=0x%0h pend=%0d, expected 1 0 0 0x0 0",
               req__RDY, startSignal__ENA, done__ENA, done_v, pending);
    end
    tick(2);
    nRST = 1'b1;
    tick(60);
    tests_run++;
    if (n_done !== d0) begin tests_failed++; $display("FAIL rst_mid_no_record: got %0d records, expected %0d", n_done, d0); end
    tests_run++;
    if (n_start - s0 !== 1) begin tests_failed++; $display("FAIL rst_mid_pulses: got %0d, expected 1", n_start - s0); end
  endtask

  task automatic test_simultaneous;
    int d0 = n_done;
    max_amt = 62;
    drive_req(4'h5, 1'b0);
    tick(1);
    req__ENA = 1'b0;
    wait_done(d0, 200, "simul");
    tests_run++;
    if (done_cyc - start_cyc !== 64) begin tests_failed++; $display("FAIL simul_latency: got %0d cycles, expected 64", done_cyc - start_cyc); end
    tick(3);
    max_amt = 63;
    drive_req(4'h6, 1'b1);
    tick(1);
    req__ENA = 1'b0;
    wait_done(d0 + 1, 200, "late_fall");
    tests_run++;
    if (done_cyc - start_cyc !== 64) begin tests_failed++; $display("FAIL late_fall_latency: got %0d cycles, expected 64", done_cyc - start_cyc); end
    tick(5);
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_backpressure();
    test_reset_midflight();
    test_simultaneous();
    tests_run++;
    if (exp_q.size() !== 0) begin tests_failed++; $display("FAIL final_leftover: %0d records outstanding, expected 0", exp_q.size()); end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
